// File: rtl/pm_arbiter.sv
// Round-robin arbiter that shares one pm32 multiplier among NREQ requesters.
// Each grant runs one LOAD/START/BUSY/RESP sequence on the multiplier.
module pm_arbiter #(
  parameter int SIZE    = 32,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 2 * SIZE + 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*SIZE-1:0]   req_mc,
  input  logic [NREQ*SIZE-1:0]   req_mp,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ack,
  output logic [2*SIZE-1:0]      rsp_p,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   pm_rst,
  output logic                   pm_start,
  output logic [SIZE-1:0]        pm_mc,
  output logic [SIZE-1:0]        pm_mp,
  input  logic [2*SIZE-1:0]      pm_p,
  input  logic                   pm_done,
  output logic [2:0]             state_dbg
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  // Handshakes: req is held with its operands until the one-cycle gnt pulse;
  // rsp_valid[id] is held with rsp_p/rsp_err until rsp_ack[id] is seen high on
  // a rising edge, at which point the transfer completes.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_BUSY  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [IW-1:0]     ptr, ptr_n;
  logic [IW-1:0]     id, id_n;
  logic [IW-1:0]     sel_id, rr_idx;
  logic              found;
  logic [CW-1:0]     cnt, cnt_n;
  logic [NREQ-1:0]   gnt_n, rsp_valid_n;
  logic [2*SIZE-1:0] rsp_p_n;
  logic              rsp_err_n, busy_n, pm_rst_n, pm_start_n;
  logic [SIZE-1:0]   mc_n, mp_n;

  assign state_dbg = state;

  // First requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found  = 1'b0;
    sel_id = '0;
    rr_idx = '0;
    for (int j = 0; j < NREQ; j++) begin
      rr_idx = IW'((int'(ptr) + j) % NREQ);
      if (!found && req[rr_idx]) begin
        found  = 1'b1;
        sel_id = rr_idx;
      end
    end
  end

  // Registered outputs take the value that belongs to the state being entered.
  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    id_n        = id;
    cnt_n       = cnt;
    gnt_n       = '0;
    rsp_valid_n = rsp_valid;
    rsp_p_n     = rsp_p;
    rsp_err_n   = rsp_err;
    pm_rst_n    = pm_rst;
    pm_start_n  = 1'b0;
    mc_n        = pm_mc;
    mp_n        = pm_mp;
    case (state)
      S_IDLE: begin
        pm_rst_n = 1'b1;
        if (found) begin
          gnt_n   = NREQ'(1) << sel_id;
          id_n    = sel_id;
          mc_n    = req_mc[sel_id*SIZE +: SIZE];
          mp_n    = req_mp[sel_id*SIZE +: SIZE];
          ptr_n   = (sel_id == IW'(NREQ - 1)) ? '0 : sel_id + IW'(1);
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        pm_rst_n   = 1'b0;
        pm_start_n = 1'b1;
        state_n    = S_START;
      end
      S_START: begin
        cnt_n   = '0;
        state_n = S_BUSY;
      end
      S_BUSY: begin
        if (pm_done) begin
          rsp_p_n     = pm_p;
          rsp_err_n   = 1'b0;
          rsp_valid_n = NREQ'(1) << id;
          state_n     = S_RESP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          rsp_p_n     = '0;
          rsp_err_n   = 1'b1;
          rsp_valid_n = NREQ'(1) << id;
          state_n     = S_RESP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ack[id]) begin
          rsp_valid_n = '0;
          pm_rst_n    = 1'b1;
          state_n     = S_IDLE;
        end
      end
      default: begin
        pm_rst_n = 1'b1;
        state_n  = S_IDLE;
      end
    endcase
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= '0;
      id        <= '0;
      cnt       <= '0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_p     <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      pm_rst    <= 1'b1;
      pm_start  <= 1'b0;
      pm_mc     <= '0;
      pm_mp     <= '0;
    end else begin
      ptr       <= ptr_n;
      id        <= id_n;
      cnt       <= cnt_n;
      gnt       <= gnt_n;
      rsp_valid <= rsp_valid_n;
      rsp_p     <= rsp_p_n;
      rsp_err   <= rsp_err_n;
      busy      <= busy_n;
      pm_rst    <= pm_rst_n;
      pm_start  <= pm_start_n;
      pm_mc     <= mc_n;
      pm_mp     <= mp_n;
    end
  end

endmodule

// File: tb/tb_pm_arbiter.sv
// Bench for pm_arbiter: transaction-level round-robin model feeding a scoreboard,
// with a behavioural pm32 whose per-operation latency is chosen by the stimulus.
module tb_pm_arbiter;

  localparam int SIZE    = 32;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 2 * SIZE + 8;
  localparam int IW      = 2;
  localparam int EW      = IW + 1 + 2 * SIZE;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req;
  logic [NREQ*SIZE-1:0] req_mc, req_mp;
  logic [NREQ-1:0]      gnt, rsp_valid, rsp_ack;
  logic [2*SIZE-1:0]    rsp_p;
  logic                 rsp_err, busy, pm_rst, pm_start;
  logic [SIZE-1:0]      pm_mc, pm_mp;
  logic [2*SIZE-1:0]    pm_p = '0;
  logic                 pm_done = 1'b0;
  logic [2:0]           state_dbg;

  pm_arbiter #(.SIZE(SIZE), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_mc(req_mc), .req_mp(req_mp),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ack(rsp_ack), .rsp_p(rsp_p),
    .rsp_err(rsp_err), .busy(busy), .pm_rst(pm_rst), .pm_start(pm_start),
    .pm_mc(pm_mc), .pm_mp(pm_mp), .pm_p(pm_p), .pm_done(pm_done),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            dly_q[$];
  int            gnt_q[$];
  int            lat_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            drv_to = 0;
  int            drv_to_seen = 0;
  bit            fin_req = 0;
  bit            fin_ack = 0;

  // ---------------- behavioural pm32 ----------------
  int pm_cnt = 0;
  int pm_l;
  always @(posedge clk) begin
    if (pm_rst) begin
      pm_done <= 1'b0;
      pm_cnt  <= 0;
      pm_p    <= '0;
    end else if (pm_start) begin
      pm_l = (lat_q.size() != 0) ? lat_q.pop_front() : 1;
      pm_cnt  <= pm_l;
      pm_done <= 1'b0;
    end else if (pm_cnt == 1) begin
      pm_done <= 1'b1;
      pm_p    <= {{SIZE{1'b0}}, pm_mc} * {{SIZE{1'b0}}, pm_mp};
      pm_cnt  <= 0;
    end else if (pm_cnt > 1) begin
      pm_cnt <= pm_cnt - 1;
    end
  end

  // ---------------- monitor ----------------
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  bit                ack_seen = 0;
  bit                prev_gnt = 0;
  bit                prev_rv = 0;
  int                start_cyc = 0;
  logic [NREQ-1:0]   held_v;
  logic [2*SIZE-1:0] held_p;
  logic              held_e;
  logic [EW-1:0]     e;
  int                eg, ed;

  always @(posedge clk) ack_seen <= |(rsp_ack & rsp_valid);

  always @(negedge clk) begin
    if (drv_to != drv_to_seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL driver_wait: wait budget expired %0d time(s), required 0", drv_to);
      drv_to_seen = drv_to;
    end
    if (rst) begin
      check("reset_ctrl", {gnt, rsp_valid, rsp_err, busy, pm_start, pm_rst}, {{(2*NREQ+4){1'b0}}, 1'b1});
      check("reset_data", {rsp_p, pm_mc, pm_mp}, '0);
      prev_gnt = 0;
      prev_rv  = 0;
    end else begin
      if (prev_gnt) begin
        check("start_pulse", {gnt, pm_rst, pm_start}, {{NREQ{1'b0}}, 2'b01});
        start_cyc = cyc;
      end
      if (gnt != 0) begin
        if (gnt_q.size() == 0) check("gnt_unexpected", gnt, 0);
        else begin
          eg = gnt_q.pop_front();
          check("gnt_id", gnt, NREQ'(1) << eg);
        end
        check("load_ctrl", {pm_rst, pm_start, busy}, 3'b101);
      end
      if (rsp_valid != 0 && !prev_rv) begin
        if (exp_q.size() == 0) check("rsp_unexpected", rsp_valid, 0);
        else begin
          e  = exp_q.pop_front();
          ed = dly_q.pop_front();
          check("rsp_valid", rsp_valid, NREQ'(1) << e[EW-1 -: IW]);
          check("rsp_p", rsp_p, e[2*SIZE-1:0]);
          check("rsp_err", rsp_err, e[2*SIZE]);
          check("latency", cyc - start_cyc, ed);
          check("busy_resp", busy, 1'b1);
        end
        held_v = rsp_valid;
        held_p = rsp_p;
        held_e = rsp_err;
      end else if (rsp_valid != 0) begin
        check("rsp_hold", {gnt, rsp_valid, rsp_err, rsp_p}, {{NREQ{1'b0}}, held_v, held_e, held_p});
      end else if (prev_rv) begin
        check("ack_release", {ack_seen, busy}, 2'b10);
      end
      prev_gnt = (gnt != 0);
      prev_rv  = (rsp_valid != 0);
    end
    if (fin_req && !fin_ack) begin
      check("queues_drained", exp_q.size() + gnt_q.size() + dly_q.size(), 0);
      fin_ack = 1;
    end
  end

  // ---------------- reference model + driver ----------------
  logic [SIZE-1:0] op_mc[NREQ];
  logic [SIZE-1:0] op_mp[NREQ];
  int              m_ptr = 0;

  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) begin
      r = $urandom_range(0, 2);
      return (r == 0) ? TIMEOUT - 1 : (r == 1) ? TIMEOUT : 1000;
    end
    return $urandom_range(1, 8);
  endfunction

  task automatic run_phase(input logic [NREQ-1:0] set, input int count, input bit hold,
                           input int lat_fixed, input int dly_fixed);
    logic [NREQ-1:0]   pend;
    logic [NREQ-1:0]   noise;
    logic [2*SIZE-1:0] prod;
    bit                err, waiting;
    int                id, lat, served, budget, wait_left, ack_id;
    pend = set;
    for (int k = 0; k < count; k++) begin
      id = -1;
      for (int j = 0; j < NREQ; j++)
        if (id < 0 && pend[(m_ptr + j) % NREQ]) id = (m_ptr + j) % NREQ;
      lat  = (lat_fixed > 0) ? lat_fixed : pick_lat();
      err  = (lat > TIMEOUT - 1);
      prod = err ? '0 : {{SIZE{1'b0}}, op_mc[id]} * {{SIZE{1'b0}}, op_mp[id]};
      exp_q.push_back({IW'(id), err, prod});
      dly_q.push_back(err ? TIMEOUT + 1 : lat + 2);
      gnt_q.push_back(id);
      lat_q.push_back(lat);
      if (!hold) pend[id] = 1'b0;
      m_ptr = (id + 1) % NREQ;
    end
    for (int i = 0; i < NREQ; i++) begin
      req_mc[i*SIZE +: SIZE] = op_mc[i];
      req_mp[i*SIZE +: SIZE] = op_mp[i];
    end
    req = set;
    served = 0;
    budget = 0;
    waiting = 0;
    wait_left = 0;
    ack_id = 0;
    while (served < count && budget < 5000) begin
      @(negedge clk);
      budget++;
      rsp_ack = '0;
      if (rsp_valid != 0) begin
        if (!waiting) begin
          waiting   = 1;
          wait_left = (dly_fixed >= 0) ? dly_fixed : $urandom_range(0, 12);
          for (int j = 0; j < NREQ; j++) if (rsp_valid[j]) ack_id = j;
        end
        if (wait_left == 0) begin
          rsp_ack[ack_id] = 1'b1;
          served++;
          waiting = 0;
          if (served == count) req = '0;
          else if (!hold) req[ack_id] = 1'b0;
        end else begin
          wait_left--;
          noise = NREQ'($urandom);
          noise[ack_id] = 1'b0;
          rsp_ack = noise;
        end
      end
    end
    if (budget >= 5000) drv_to++;
    @(negedge clk);
    rsp_ack = '0;
    req = '0;
  endtask

  initial begin
    int bud;
    logic [NREQ-1:0] set;
    req = '0; req_mc = '0; req_mp = '0; rsp_ack = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // contention straight out of reset: 0,1,2,3,0
    for (int i = 0; i < NREQ; i++) begin
      op_mc[i] = SIZE'(i + 3);
      op_mp[i] = SIZE'(11 * (i + 1));
    end
    run_phase(4'b1111, 5, 1'b1, 4, -1);

    // single request 7*6 with a 10-cycle withheld ack
    op_mc[0] = 7; op_mp[0] = 6;
    run_phase(4'b0001, 1, 1'b0, 3, 10);

    // max operands
    op_mc[2] = '1; op_mp[2] = '1;
    run_phase(4'b0100, 1, 1'b0, 5, -1);

    // timeout and the done-on-last-cycle boundary
    op_mc[1] = SIZE'($urandom); op_mp[1] = SIZE'($urandom);
    run_phase(4'b0010, 1, 1'b0, 1000, -1);
    run_phase(4'b0010, 1, 1'b0, TIMEOUT - 1, -1);
    run_phase(4'b0010, 1, 1'b0, TIMEOUT, -1);

    for (int p = 0; p < 15; p++) begin
      for (int i = 0; i < NREQ; i++) begin
        op_mc[i] = ($urandom_range(0, 7) == 0) ? '1 : SIZE'($urandom);
        op_mp[i] = ($urandom_range(0, 7) == 0) ? '0 : SIZE'($urandom);
      end
      set = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      if ($urandom_range(0, 3) == 0) run_phase(set, $urandom_range(1, 6), 1'b1, 0, -1);
      else run_phase(set, $countones(set), 1'b0, 0, -1);
    end

    // reset while BUSY: no response, next grant goes to requester 0
    op_mc[2] = SIZE'($urandom); op_mp[2] = SIZE'($urandom);
    req_mc[2*SIZE +: SIZE] = op_mc[2];
    req_mp[2*SIZE +: SIZE] = op_mp[2];
    gnt_q.push_back(2);
    lat_q.push_back(1000);
    req = 4'b0100;
    bud = 0;
    while (!pm_start && bud < 100) begin
      @(negedge clk);
      bud++;
    end
    if (bud >= 100) drv_to++;
    req = '0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    lat_q.delete();
    m_ptr = 0;
    for (int i = 0; i < NREQ; i++) begin
      op_mc[i] = SIZE'($urandom);
      op_mp[i] = SIZE'($urandom);
    end
    run_phase(4'b1111, 2, 1'b1, 2, 0);

    repeat (3) @(negedge clk);
    fin_req = 1;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
